srpt_fetch_dma: RTL and testbench

Downstream consumer of the SRPT fetch queue. It takes each ACTIVE 64-byte fetch entry, looks up the RPC's host buffer base address, and issues one DMA read request into the on-chip data buffer. It tracks up to 8 outstanding reads by tag. On each read completion it emits an `SRPT_DBUFF_UPDATE` entry, which feeds the data-buffer update input of the fetch queue.

---
 rtl/srpt_fetch_dma_pkg.sv | 65 ++++++
 rtl/srpt_fetch_dma_tag_pool.sv | 45 ++++
 rtl/srpt_fetch_dma.sv | 175 +++++++++++++++++
 tb/tb_srpt_fetch_dma.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srpt_fetch_dma_pkg.sv
// Shared definitions for the SRPT fetch DMA engine: queue entry layout,
// SRPT priority codes, data buffer geometry and DMA request layout.
package srpt_fetch_dma_pkg;

    // Fetch/update queue entry layout
    localparam int ENTRY_W         = 99;
    localparam int RPC_ID_LSB      = 0;
    localparam int RPC_ID_MSB      = 15;
    localparam int DBUFF_ID_LSB    = 16;
    localparam int DBUFF_ID_MSB    = 24;
    localparam int REMAINING_LSB   = 26;
    localparam int REMAINING_MSB   = 45;
    localparam int DBUFFERED_LSB   = 46;
    localparam int DBUFFERED_MSB   = 65;
    localparam int GRANTED_LSB     = 66;
    localparam int GRANTED_MSB     = 85;
    localparam int PRIORITY_LSB    = 86;
    localparam int PRIORITY_MSB    = 88;

    // Table and tag pool geometry
    localparam int MAX_RPCS        = 64;
    localparam int RPC_IDX_W       = 6;
    localparam int MAX_OUTSTANDING = 8;
    localparam int TAG_W           = 3;

    // On-chip data buffer geometry
    localparam int CACHE_BLOCK_SIZE = 64;
    localparam int CACHE_SIZE       = 16384;
    localparam int CACHE_OFF_W      = $clog2(CACHE_SIZE);

    // DMA read request layout
    localparam int DMA_REQ_W              = 97;
    localparam int DMA_REQ_LEN_LSB        = 0;
    localparam int DMA_REQ_LEN_MSB        = 6;
    localparam int DMA_REQ_DBUFF_ADDR_LSB = 7;
    localparam int DMA_REQ_DBUFF_ADDR_MSB = 29;
    localparam int DMA_REQ_HOST_ADDR_LSB  = 30;
    localparam int DMA_REQ_HOST_ADDR_MSB  = 93;
    localparam int DMA_REQ_TAG_LSB        = 94;
    localparam int DMA_REQ_TAG_MSB        = 96;

    typedef enum logic [2:0] {
        SRPT_INVALIDATE   = 3'd0,
        SRPT_DBUFF_UPDATE = 3'd1,
        SRPT_GRANT_UPDATE = 3'd2,
        SRPT_EMPTY        = 3'd3,
        SRPT_BLOCKED      = 3'd4,
        SRPT_ACTIVE       = 3'd5
    } srptPriority_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_ISSUE  = 2'd2
    } reqState_e;

    // One cache block at most; a zero remaining count still moves a full block
    function automatic logic [6:0] calcLen(input logic [19:0] remaining);
        if (remaining == 20'd0 || remaining >= 20'(CACHE_BLOCK_SIZE)) begin
            return 7'(CACHE_BLOCK_SIZE);
        end
        return remaining[6:0];
    endfunction

endpackage

// File: rtl/srpt_fetch_dma_tag_pool.sv
// Tag pool for outstanding DMA reads: busy bitmap, lowest-free tag
// selection, allocate/free ports and an all-busy flag.
module srpt_tag_pool
    import srpt_fetch_dma_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alloc_i,
    output logic [TAG_W-1:0]           alloc_tag_o,
    input  logic                       free_i,
    input  logic [TAG_W-1:0]           free_tag_i,
    output logic [MAX_OUTSTANDING-1:0] busy_o,
    output logic                       empty_o
);

    logic [MAX_OUTSTANDING-1:0] busy_q;

    assign busy_o  = busy_q;
    assign empty_o = &busy_q;

    // Pick the lowest-numbered free tag; scanning downward lets the lowest win
    always_comb begin
        alloc_tag_o = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_tag_o = TAG_W'(i);
            end
        end
    end

    // Allocation and release touch different tags, so both may happen together
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            if (alloc_i && !empty_o) begin
                busy_q[alloc_tag_o] <= 1'b1;
            end
            if (free_i) begin
                busy_q[free_tag_i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/srpt_fetch_dma.sv
// SRPT fetch DMA engine: turns fetch queue entries into tagged DMA reads of
// one cache block each and reports each completion as a data-buffer update.
module srpt_fetch_dma
    import srpt_fetch_dma_pkg::*;
(
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_ce,
    input  logic                 ap_start,
    input  logic                 fetch_in_empty_i,
    output logic                 fetch_in_read_en_o,
    input  logic [ENTRY_W-1:0]   fetch_in_data_i,
    input  logic                 addr_wr_en_i,
    input  logic [RPC_IDX_W-1:0] addr_wr_rpc_i,
    input  logic [63:0]          addr_wr_data_i,
    input  logic                 dma_req_full_i,
    output logic                 dma_req_write_en_o,
    output logic [DMA_REQ_W-1:0] dma_req_data_o,
    input  logic                 dma_cpl_empty_i,
    output logic                 dma_cpl_read_en_o,
    input  logic [TAG_W-1:0]     dma_cpl_tag_i,
    input  logic                 dbuff_out_full_i,
    output logic                 dbuff_out_write_en_o,
    output logic [ENTRY_W-1:0]   dbuff_out_data_o,
    output logic                 ap_idle,
    output logic                 ap_done,
    output logic                 ap_ready
);

    logic                       advance;
    logic                       popFetch;
    logic                       issueReq;
    logic                       cplPop;
    logic                       cplHit;

    reqState_e                  state_q;
    logic [RPC_IDX_W-1:0]       reqRpcIdx_q;
    logic [8:0]                 reqDbuffId_q;
    logic [19:0]                reqRemaining_q;
    logic [19:0]                reqDbuffered_q;
    logic [TAG_W-1:0]           reqTag_q;
    logic [63:0]                reqBase_q;

    logic [63:0]                baseTable [MAX_RPCS];

    logic [15:0]                tagRpc_q    [MAX_OUTSTANDING];
    logic [8:0]                 tagDbuffId_q[MAX_OUTSTANDING];
    logic [19:0]                tagOffset_q [MAX_OUTSTANDING];
    logic [19:0]                tagOffset_d;

    logic [TAG_W-1:0]           allocTag;
    logic [MAX_OUTSTANDING-1:0] tagBusy;
    logic                       poolEmpty;

    logic [15:0]                inRpcId;
    logic [8:0]                 inDbuffId;
    logic [19:0]                inRemaining;
    logic [19:0]                inDbuffered;
    logic                       unusedFetchBits;

    assign inRpcId     = fetch_in_data_i[RPC_ID_MSB:RPC_ID_LSB];
    assign inDbuffId   = fetch_in_data_i[DBUFF_ID_MSB:DBUFF_ID_LSB];
    assign inRemaining = fetch_in_data_i[REMAINING_MSB:REMAINING_LSB];
    assign inDbuffered = fetch_in_data_i[DBUFFERED_MSB:DBUFFERED_LSB];

    // Grant, priority and padding bits of an incoming entry play no part here
    assign unusedFetchBits = ^{fetch_in_data_i[ENTRY_W-1:PRIORITY_LSB],
                               fetch_in_data_i[GRANTED_MSB:GRANTED_LSB],
                               fetch_in_data_i[DBUFF_ID_MSB+1]};

    // Nothing moves while the block is stalled or held in reset
    assign advance  = ap_ce && ap_start && !ap_rst;
    assign popFetch = advance && (state_q == ST_IDLE) && fetch_in_empty_i && !poolEmpty;
    assign issueReq = advance && (state_q == ST_ISSUE) && dma_req_full_i;
    assign cplPop   = advance && dma_cpl_empty_i && dbuff_out_full_i;
    assign cplHit   = cplPop && tagBusy[dma_cpl_tag_i];

    assign tagOffset_d = inDbuffered + 20'(calcLen(inRemaining));

    assign fetch_in_read_en_o   = popFetch;
    assign dma_req_write_en_o   = issueReq;
    assign dma_cpl_read_en_o    = cplPop;
    assign dbuff_out_write_en_o = cplHit;
    assign ap_idle              = !ap_rst && (state_q == ST_IDLE) && (tagBusy == '0);
    assign ap_done              = 1'b1;
    assign ap_ready             = 1'b1;

    srpt_tag_pool u_tagPool (
        .clk_i       (ap_clk),
        .rst_i       (ap_rst),
        .alloc_i     (popFetch),
        .alloc_tag_o (allocTag),
        .free_i      (cplHit),
        .free_tag_i  (dma_cpl_tag_i),
        .busy_o      (tagBusy),
        .empty_o     (poolEmpty)
    );

    // Host base table; a write racing a LOOKUP read of the same slot lands after the read
    always_ff @(posedge ap_clk) begin
        if (advance && addr_wr_en_i) begin
            baseTable[addr_wr_rpc_i] <= addr_wr_data_i;
        end
    end

    // Remember what each tag is fetching so its completion can be reported
    always_ff @(posedge ap_clk) begin
        if (popFetch) begin
            tagRpc_q[allocTag]     <= inRpcId;
            tagDbuffId_q[allocTag] <= inDbuffId;
            tagOffset_q[allocTag]  <= tagOffset_d;
        end
    end

    // Request FSM: pop and latch an entry, read its base address, then issue
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q        <= ST_IDLE;
            reqRpcIdx_q    <= '0;
            reqDbuffId_q   <= '0;
            reqRemaining_q <= '0;
            reqDbuffered_q <= '0;
            reqTag_q       <= '0;
            reqBase_q      <= '0;
        end else if (advance) begin
            case (state_q)
                ST_IDLE: begin
                    if (popFetch) begin
                        reqRpcIdx_q    <= inRpcId[RPC_IDX_W-1:0];
                        reqDbuffId_q   <= inDbuffId;
                        reqRemaining_q <= inRemaining;
                        reqDbuffered_q <= inDbuffered;
                        reqTag_q       <= allocTag;
                        state_q        <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    reqBase_q <= baseTable[reqRpcIdx_q];
                    state_q   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (dma_req_full_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Request word is held steady for the whole of ISSUE and is zero otherwise
    always_comb begin
        dma_req_data_o = '0;
        if (state_q == ST_ISSUE) begin
            dma_req_data_o[DMA_REQ_LEN_MSB:DMA_REQ_LEN_LSB]               = calcLen(reqRemaining_q);
            dma_req_data_o[DMA_REQ_DBUFF_ADDR_MSB:DMA_REQ_DBUFF_ADDR_LSB] =
                {reqDbuffId_q, reqDbuffered_q[CACHE_OFF_W-1:0]};
            dma_req_data_o[DMA_REQ_HOST_ADDR_MSB:DMA_REQ_HOST_ADDR_LSB]   =
                reqBase_q + {44'd0, reqDbuffered_q};
            dma_req_data_o[DMA_REQ_TAG_MSB:DMA_REQ_TAG_LSB]               = reqTag_q;
        end
    end

    // Completion for a live tag becomes a data-buffer update in the same cycle
    always_comb begin
        dbuff_out_data_o = '0;
        if (cplHit) begin
            dbuff_out_data_o[RPC_ID_MSB:RPC_ID_LSB]       = tagRpc_q[dma_cpl_tag_i];
            dbuff_out_data_o[DBUFF_ID_MSB:DBUFF_ID_LSB]   = tagDbuffId_q[dma_cpl_tag_i];
            dbuff_out_data_o[DBUFFERED_MSB:DBUFFERED_LSB] = tagOffset_q[dma_cpl_tag_i];
            dbuff_out_data_o[PRIORITY_MSB:PRIORITY_LSB]   = SRPT_DBUFF_UPDATE;
        end
    end

endmodule

// File: tb/tb_srpt_fetch_dma.sv
// Self-checking bench for srpt_fetch_dma: directed scenarios followed by a
// randomized mix of fetches and completions, checked against a tag-level model.
module tb_srpt_fetch_dma;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_ce;
    logic        ap_start;
    logic        fetch_in_empty_i;
    logic        fetch_in_read_en_o;
    logic [98:0] fetch_in_data_i;
    logic        addr_wr_en_i;
    logic [5:0]  addr_wr_rpc_i;
    logic [63:0] addr_wr_data_i;
    logic        dma_req_full_i;
    logic        dma_req_write_en_o;
    logic [96:0] dma_req_data_o;
    logic        dma_cpl_empty_i;
    logic        dma_cpl_read_en_o;
    logic [2:0]  dma_cpl_tag_i;
    logic        dbuff_out_full_i;
    logic        dbuff_out_write_en_o;
    logic [98:0] dbuff_out_data_o;
    logic        ap_idle;
    logic        ap_done;
    logic        ap_ready;

    int checks   = 0;
    int failures = 0;

    // Reference state: host base addresses and what each live tag is fetching
    logic [63:0] baseMem [64];
    logic        mValid  [8];
    logic [15:0] mRpc    [8];
    logic [8:0]  mDbuff  [8];
    logic [19:0] mOff    [8];

    srpt_fetch_dma dut (
        .ap_clk               (ap_clk),
        .ap_rst               (ap_rst),
        .ap_ce                (ap_ce),
        .ap_start             (ap_start),
        .fetch_in_empty_i     (fetch_in_empty_i),
        .fetch_in_read_en_o   (fetch_in_read_en_o),
        .fetch_in_data_i      (fetch_in_data_i),
        .addr_wr_en_i         (addr_wr_en_i),
        .addr_wr_rpc_i        (addr_wr_rpc_i),
        .addr_wr_data_i       (addr_wr_data_i),
        .dma_req_full_i       (dma_req_full_i),
        .dma_req_write_en_o   (dma_req_write_en_o),
        .dma_req_data_o       (dma_req_data_o),
        .dma_cpl_empty_i      (dma_cpl_empty_i),
        .dma_cpl_read_en_o    (dma_cpl_read_en_o),
        .dma_cpl_tag_i        (dma_cpl_tag_i),
        .dbuff_out_full_i     (dbuff_out_full_i),
        .dbuff_out_write_en_o (dbuff_out_write_en_o),
        .dbuff_out_data_o     (dbuff_out_data_o),
        .ap_idle              (ap_idle),
        .ap_done              (ap_done),
        .ap_ready             (ap_ready)
    );

    always #5 ap_clk = ~ap_clk;

    // Safety net in case the run wanders off
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
            $error("[TB] check %s disagreed: observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fetchValid, input logic [98:0] entry,
                                 input logic cplValid, input logic [2:0] cplTag,
                                 input logic reqFull, input logic outFull);
        fetch_in_empty_i = fetchValid;
        fetch_in_data_i  = entry;
        dma_cpl_empty_i  = cplValid;
        dma_cpl_tag_i    = cplTag;
        dma_req_full_i   = reqFull;
        dbuff_out_full_i = outFull;
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic int lowestFree();
        for (int i = 0; i < 8; i++) begin
            if (!mValid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic anyValid();
        for (int i = 0; i < 8; i++) begin
            if (mValid[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int refLen(input logic [19:0] rem);
        if (rem == 0) return 64;
        return (rem < 64) ? int'(rem) : 64;
    endfunction

    function automatic logic [98:0] makeEntry(input logic [15:0] rpc, input logic [8:0] dbuff,
                                              input logic [19:0] rem, input logic [19:0] dbuffered);
        logic [98:0] e;
        e         = '0;
        e[15:0]   = rpc;
        e[24:16]  = dbuff;
        e[45:26]  = rem;
        e[65:46]  = dbuffered;
        e[85:66]  = 20'($urandom);
        e[88:86]  = 3'd5;
        return e;
    endfunction

    function automatic logic [98:0] randEntry();
        logic [19:0] rem;
        case ($urandom_range(0, 3))
            0:       rem = 20'd0;
            1:       rem = 20'($urandom_range(1, 63));
            2:       rem = 20'd64;
            default: rem = 20'($urandom);
        endcase
        return makeEntry(16'($urandom), 9'($urandom), rem, 20'($urandom));
    endfunction

    // Expected request word built from field values with plain arithmetic
    function automatic logic [96:0] refReq(input logic [98:0] entry, input int tag);
        logic [63:0] host;
        int          dbuffAddr;
        logic [19:0] dbuffered;
        dbuffered = entry[65:46];
        host      = baseMem[entry[5:0]] + 64'(dbuffered);
        dbuffAddr = int'(entry[24:16]) * 16384 + int'(dbuffered) % 16384;
        return (97'(tag) << 94) | (97'(host) << 30) | (97'(dbuffAddr) << 7) | 97'(refLen(entry[45:26]));
    endfunction

    function automatic logic [98:0] refUpd(input int tag);
        return 99'(mRpc[tag]) | (99'(mDbuff[tag]) << 16) | (99'(mOff[tag]) << 46) | (99'(1) << 86);
    endfunction

    task automatic writeBase(input int idx, input logic [63:0] val);
        addr_wr_en_i   = 1'b1;
        addr_wr_rpc_i  = 6'(idx);
        addr_wr_data_i = val;
        tick();
        addr_wr_en_i   = 1'b0;
        baseMem[idx]   = val;
    endtask

    // One full fetch: pop, lookup, issue with an optional stall and table collision
    task automatic issueOne(input logic [98:0] entry, input int stall,
                            input logic collide, input logic [63:0] newBase);
        int          t;
        logic [96:0] expReq;
        t = lowestFree();
        applyStimulus(1'b1, entry, 1'b0, 3'd0, 1'b1, 1'b1);
        #1;
        checkOutput("fetch_pop", fetch_in_read_en_o, t >= 0);
        if (t < 0) begin
            tick();
            applyStimulus(1'b0, '0, 1'b0, 3'd0, 1'b1, 1'b1);
            return;
        end
        expReq    = refReq(entry, t);
        mValid[t] = 1'b1;
        mRpc[t]   = entry[15:0];
        mDbuff[t] = entry[24:16];
        mOff[t]   = entry[65:46] + 20'(refLen(entry[45:26]));
        tick();
        applyStimulus(1'b0, '0, 1'b0, 3'd0, stall == 0, 1'b1);
        if (collide) begin
            addr_wr_en_i   = 1'b1;
            addr_wr_rpc_i  = entry[5:0];
            addr_wr_data_i = newBase;
        end
        #1;
        checkOutput("lookup_no_pop", fetch_in_read_en_o, 1'b0);
        checkOutput("lookup_no_req", dma_req_write_en_o, 1'b0);
        tick();
        if (collide) begin
            addr_wr_en_i          = 1'b0;
            baseMem[entry[5:0]]   = newBase;
        end
        for (int s = 0; s < stall; s++) begin
            #1;
            checkOutput("req_stalled", dma_req_write_en_o, 1'b0);
            checkOutput("req_held", dma_req_data_o, expReq);
            tick();
        end
        dma_req_full_i = 1'b1;
        #1;
        checkOutput("req_push", dma_req_write_en_o, 1'b1);
        checkOutput("req_data", dma_req_data_o, expReq);
        tick();
        checkOutput("req_single", dma_req_write_en_o, 1'b0);
    endtask

    // One completion; only live tags produce an update
    task automatic complete(input int tag, input logic outFull);
        logic expHit;
        applyStimulus(1'b0, '0, 1'b1, 3'(tag), 1'b1, outFull);
        #1;
        checkOutput("idle_flag", ap_idle, !anyValid());
        expHit = outFull && mValid[tag];
        checkOutput("cpl_pop", dma_cpl_read_en_o, outFull);
        checkOutput("upd_push", dbuff_out_write_en_o, expHit);
        checkOutput("upd_data", dbuff_out_data_o, expHit ? refUpd(tag) : 99'd0);
        tick();
        if (expHit) mValid[tag] = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 3'd0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [98:0] e9;
        logic [96:0] expReq;
        for (int i = 0; i < 8; i++) mValid[i] = 1'b0;
        ap_ce          = 1'b1;
        ap_start       = 1'b1;
        addr_wr_en_i   = 1'b0;
        addr_wr_rpc_i  = '0;
        addr_wr_data_i = '0;

        // Reset with requests pending on every input: nothing may move
        ap_rst = 1'b1;
        applyStimulus(1'b1, makeEntry(16'd1, 9'd1, 20'd5, 20'd0), 1'b1, 3'd0, 1'b1, 1'b1);
        repeat (3) @(posedge ap_clk);
        #1;
        checkOutput("rst_fetch_pop", fetch_in_read_en_o, 1'b0);
        checkOutput("rst_cpl_pop", dma_cpl_read_en_o, 1'b0);
        checkOutput("rst_req_we", dma_req_write_en_o, 1'b0);
        checkOutput("rst_req_data", dma_req_data_o, 97'd0);
        checkOutput("rst_upd_we", dbuff_out_write_en_o, 1'b0);
        checkOutput("rst_upd_data", dbuff_out_data_o, 99'd0);
        checkOutput("rst_idle", ap_idle, 1'b0);
        checkOutput("rst_done", ap_done, 1'b1);
        checkOutput("rst_ready", ap_ready, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 3'd0, 1'b1, 1'b1);
        ap_rst = 1'b0;
        tick();
        checkOutput("post_rst_idle", ap_idle, 1'b1);

        // Load the base table
        for (int i = 0; i < 64; i++) writeBase(i, {$urandom, $urandom});
        writeBase(7, 64'h1000_0000);

        // Basic fetch, then a wrapped offset with a same-cycle table write
        issueOne(makeEntry(16'd7, 9'd7, 20'd1000000, 20'd0), 0, 1'b0, '0);
        issueOne(makeEntry(16'd7, 9'd3, 20'd40, 20'd16400), 0, 1'b1, 64'h2222_0000_0000_0000);

        // A stalled handshake holds everything
        ap_start = 1'b0;
        applyStimulus(1'b1, randEntry(), 1'b1, 3'd0, 1'b1, 1'b1);
        #1;
        checkOutput("stall_fetch_pop", fetch_in_read_en_o, 1'b0);
        checkOutput("stall_cpl_pop", dma_cpl_read_en_o, 1'b0);
        tick();
        ap_start = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Request FIFO back-pressure for five cycles
        issueOne(randEntry(), 5, 1'b0, '0);

        // Fill the pool; the ninth entry must wait
        for (int k = 0; k < 5; k++) issueOne(randEntry(), 0, 1'b0, '0);
        e9 = randEntry();
        applyStimulus(1'b1, e9, 1'b0, 3'd0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("pool_full_no_pop", fetch_in_read_en_o, 1'b0);
            tick();
        end
        applyStimulus(1'b1, e9, 1'b1, 3'd3, 1'b1, 1'b1);
        #1;
        checkOutput("free3_cpl_pop", dma_cpl_read_en_o, 1'b1);
        checkOutput("free3_upd_push", dbuff_out_write_en_o, 1'b1);
        checkOutput("free3_upd_data", dbuff_out_data_o, refUpd(3));
        checkOutput("free3_not_yet", fetch_in_read_en_o, 1'b0);
        tick();
        mValid[3] = 1'b0;
        issueOne(e9, 0, 1'b0, '0);

        // Out-of-order completions, a repeat, and a blocked update FIFO
        complete(2, 1'b1);
        complete(0, 1'b1);
        complete(2, 1'b1);
        complete(5, 1'b0);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 5) issueOne(randEntry(), $urandom_range(0, 2), 1'b0, '0);
            else complete($urandom_range(0, 7), $urandom_range(0, 4) != 0);
        end
        for (int i = 0; i < 8; i++) begin
            if (mValid[i]) complete(i, 1'b1);
        end

        // Reset while issuing with four tags outstanding
        for (int k = 0; k < 3; k++) issueOne(randEntry(), 0, 1'b0, '0);
        e9 = randEntry();
        applyStimulus(1'b1, e9, 1'b0, 3'd0, 1'b0, 1'b1);
        #1;
        checkOutput("rst4_pop", fetch_in_read_en_o, 1'b1);
        expReq = refReq(e9, 3);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        #1;
        checkOutput("rst4_issue_held", dma_req_data_o, expReq);
        ap_rst = 1'b1;
        #1;
        checkOutput("rst4_req_we", dma_req_write_en_o, 1'b0);
        checkOutput("rst4_req_data", dma_req_data_o, 97'd0);
        checkOutput("rst4_idle", ap_idle, 1'b0);
        tick();
        ap_rst = 1'b0;
        dma_req_full_i = 1'b1;
        for (int i = 0; i < 8; i++) mValid[i] = 1'b0;
        tick();
        checkOutput("rst4_idle_after", ap_idle, 1'b1);
        checkOutput("rst4_no_req", dma_req_write_en_o, 1'b0);
        complete(1, 1'b1);
        issueOne(randEntry(), 0, 1'b0, '0);
        complete(0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
